pc_sequencer: RTL and testbench

//   Owns the program counter register of the KGP-RISC fetch stage and sequences it.
//   - Each cycle it picks the next PC from three sources: word increment (pc+1), branch target, or jump-register target.
//   - Run state is held in a small FSM: IDLE, RUN, HALT.
//   - Fetch requests to instruction memory use a valid/ready handshake.
//   - Accepted fetches are counted for performance debug.

---
 rtl/pc_sequencer_if.sv | 19 +
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Instruction-fetch request bus between the PC sequencer and instruction memory.
//   The sequencer presents a fetch address with a valid flag. The memory answers
//   with ready when it accepts that address in the current cycle.
// Signals
//   pc         fetch word address, driven by the sequencer
//   pc_valid   pc is a live fetch request, driven by the sequencer
//   imem_ready memory accepts pc this cycle, driven by the memory
// Modports
//   master  sequencer side
//   slave   instruction-memory side
interface pc_sequencer_if;
  logic [31:0] pc;
  logic        pc_valid;
  logic        imem_ready;

  modport master (output pc, output pc_valid, input imem_ready);
  modport slave  (input pc, input pc_valid, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the KGP-RISC fetch-stage program counter. On each cycle it chooses the
//   next PC from three sources, in this order: jump-register target, branch
//   target, and word increment. The run state is held in a three-state FSM
//   (IDLE, RUN, HALT). A fetch is accepted when the valid/ready handshake
//   completes, and each accepted fetch is counted for performance debug.
// Parameters
//   RESET_PC    PC loaded on reset and on start
//   IMEM_DEPTH  instruction memory depth in words (bound check only)
//   CNT_W       width of fetch_count
// Optional feature
//   PC_BOUND_CHECK_EN  when this macro is defined, a candidate next PC at or
//                      beyond IMEM_DEPTH halts the sequencer and raises fault.
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        pulse that starts execution from RESET_PC (IDLE/HALT only)
//   stall        freezes pc, state and count; redirects are ignored
//   br_*, jr_*   branch / jump redirect requests and their targets
//   halt_req     halt instruction decoded
//   imem         fetch bus (pc, pc_valid out; imem_ready in)
//   npc          pc + 1, combinational
//   halted       FSM is in HALT
//   fault        out-of-range PC detected (0 when bound check is disabled)
//   fetch_count  number of accepted fetches, wraps
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jr_taken,
  input  logic [31:0]      jr_target,
  input  logic             halt_req,
  pc_sequencer_if.master   imem,
  output logic [31:0]      npc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_n;
  logic [31:0]      pc_q, pc_n;
  logic [CNT_W-1:0] cnt_n;
  logic             fault_q, fault_n;
  logic [31:0]      cand;
  logic             adv;
  logic             bound_hit;

  assign imem.pc       = pc_q;
  assign imem.pc_valid = (state == RUN);
  assign npc           = pc_q + 32'd1;
  assign halted        = (state == HALT);
  assign fault         = fault_q;
  assign adv           = imem.pc_valid & imem.imem_ready & ~stall;

  // Candidate next PC when running unstalled. A redirect wins over the
  // increment even if the handshake completes in the same cycle.
  always_comb begin
    cand = pc_q;
    if (jr_taken)      cand = jr_target;
    else if (br_taken) cand = br_target;
    else if (adv)      cand = npc;
  end

`ifdef PC_BOUND_CHECK_EN
  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);
  assign bound_hit = (cand >= DEPTH_W);
`else
  logic unused_depth;
  assign unused_depth = ^IMEM_DEPTH;
  assign bound_hit    = 1'b0;
`endif

  // Next-state logic. halt_req takes priority over everything in RUN. An
  // out-of-range candidate halts with pc held and drops the fetch count, so
  // the PC never leaves the legal instruction memory range.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    cnt_n   = fetch_count;
    fault_n = fault_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_n = HALT;
          end else if (bound_hit) begin
            state_n = HALT;
            fault_n = 1'b1;
          end else begin
            pc_n = cand;
            if (adv) cnt_n = fetch_count + CNT_W'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
          fault_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register. rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      fetch_count <= '0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      pc_q        <= pc_n;
      fetch_count <= cnt_n;
      fault_q     <= fault_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Scoreboard bench for pc_sequencer. Each stimulus cycle drives the inputs,
//   advances a behavioural reference model, and pushes the predicted outputs
//   to a queue. After the clock edge, the prediction is popped and compared
//   against the DUT outputs. fetch_count is narrowed to 4 bits so that the
//   count wrap can be exercised. When PC_BOUND_CHECK_EN is defined, the memory
//   depth is 16 words.
module tb_pc_sequencer;

`ifdef PC_BOUND_CHECK_EN
  localparam int DEPTH = 16;
  localparam bit BOUND = 1'b1;
`else
  localparam int DEPTH = 1024;
  localparam bit BOUND = 1'b0;
`endif
  localparam int          CNT_W = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct {
    logic [31:0]      pc;
    logic             valid;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, stall, br_taken, jr_taken, halt_req;
  logic [31:0] br_target, jr_target, npc;
  logic halted, fault;
  logic [CNT_W-1:0] fetch_count;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jr_taken(jr_taken), .jr_target(jr_target),
    .halt_req(halt_req), .imem(bus), .npc(npc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int stepno   = 0;

  // Reference model state: 0 idle, 1 run, 2 halt
  int               m_state = 0;
  logic [31:0]      m_pc    = RPC;
  logic [CNT_W-1:0] m_cnt   = '0;
  logic             m_fault = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL step %0d %s: got %0h expected %0h", stepno, tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic modelStep();
    logic [31:0] nxt;
    logic        accept;
    if (rst) begin
      m_state = 0; m_pc = RPC; m_cnt = '0; m_fault = 1'b0;
    end else if (m_state == 0) begin
      if (start) begin m_state = 1; m_pc = RPC; end
    end else if (m_state == 2) begin
      if (start) begin m_state = 1; m_pc = RPC; m_fault = 1'b0; end
    end else if (!stall) begin
      accept = bus.imem_ready;
      if (halt_req) begin
        m_state = 2;
      end else begin
        if (jr_taken)      nxt = jr_target;
        else if (br_taken) nxt = br_target;
        else if (accept)   nxt = m_pc + 32'd1;
        else               nxt = m_pc;
        if (BOUND && nxt >= 32'(DEPTH)) begin
          m_state = 2; m_fault = 1'b1;
        end else begin
          m_pc = nxt;
          if (accept) m_cnt = m_cnt + 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic st, input logic rdy,
                               input logic br, input logic [31:0] bt,
                               input logic jr, input logic [31:0] jt, input logic hr);
    exp_t e;
    rst = r; start = s; stall = st; bus.imem_ready = rdy;
    br_taken = br; br_target = bt; jr_taken = jr; jr_target = jt; halt_req = hr;
    modelStep();
    e.pc = m_pc; e.valid = (m_state == 1); e.halted = (m_state == 2);
    e.fault = m_fault; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    if (q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      checkOutput("pc", bus.pc, e.pc);
      checkOutput("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
      checkOutput("npc", npc, e.pc + 32'd1);
      checkOutput("halted", 32'(halted), 32'(e.halted));
      checkOutput("fault", 32'(fault), 32'(e.fault));
      checkOutput("fetch_count", 32'(fetch_count), 32'(e.cnt));
    end
  endtask

  task automatic cyc(input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; bus.imem_ready = 1'b0;
    br_taken = 1'b0; br_target = '0; jr_taken = 1'b0; jr_target = '0; halt_req = 1'b0;
    #2;
    // Reset, then start and run four accepted fetches
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1);
    // Reach pc=5, then memory not ready for three cycles, then accept
    cyc(1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0);
    cyc(1'b1);
    // Reach pc=8; simultaneous jr and br with an accepted fetch, then br alone without ready
    cyc(1'b1); cyc(1'b1);
    applyStimulus(0, 0, 0, 1, 1, 32'h40, 1, 32'h80, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 32'h0, 0);
    // Stall blocks a redirect, which lands once stall drops
    applyStimulus(0, 0, 1, 1, 1, 32'h20, 0, 32'h0, 0);
    applyStimulus(0, 0, 1, 1, 1, 32'h20, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 1, 1, 32'h20, 0, 32'h0, 0);
    // start while running is ignored
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    // Halt at pc=0x10 even with ready high, then restart
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'h10, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 1);
    cyc(1'b1);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    cyc(1'b1);
    // PC wraps modulo 2^32 (faults instead when bound check is enabled)
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    cyc(1'b1);
    // Reset in the middle of a handshake
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
    cyc(1'b1);
    applyStimulus(1, 0, 0, 1, 1, 32'h44, 0, 32'h0, 0);
    // Start, then run from pc=14 into the memory boundary
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 32'd14, 0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    // Accept enough fetches for the 4-bit counter to wrap
    for (int i = 0; i < 17; i++) cyc(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
